conv_mem_responder: RTL

//  Memory/host-side responder for the CONV engine. Owns the image ROM (iaddr/idata) and

---
 rtl/conv_mem_responder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/conv_mem_responder.sv
// Memory/host-side responder for the CONV engine: image ROM, layer banks, host port, start handshake.
// Optional ready-to-busy watchdog is enabled by defining CONV_RSP_WDOG_EN.
module conv_mem_responder #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 12,
  parameter int N_BANKS    = 5
`ifdef CONV_RSP_WDOG_EN
  ,
  parameter int WDOG_CYCLES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  ready,
  input  logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [ADDR_WIDTH-1:0] iaddr,
  output logic [DATA_WIDTH-1:0] idata,
  input  logic [2:0]            csel,
  input  logic                  cwr,
  input  logic [ADDR_WIDTH-1:0] caddr_wr,
  input  logic [DATA_WIDTH-1:0] cdata_wr,
  input  logic                  crd,
  input  logic [ADDR_WIDTH-1:0] caddr_rd,
  output logic [DATA_WIDTH-1:0] cdata_rd,
  input  logic                  hwr,
  input  logic                  hrd,
  input  logic [2:0]            hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int         Depth  = 2 ** ADDR_WIDTH;
  localparam logic [2:0] NBanks = 3'(N_BANKS);

  typedef enum logic [1:0] {
    IDLE,
    READY,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] img_mem  [Depth];
  logic [DATA_WIDTH-1:0] bank_mem [N_BANKS][Depth];

  logic       csel_ok;
  logic       hsel_bank;
  logic       hsel_bad;
  logic [2:0] cidx;
  logic [2:0] hidx;
  logic       host_wr_ok;
  logic       img_we;
  logic       host_bank_we;
  logic       eng_we;
  logic       collide;
  logic       wdog_expire;
  logic       err_set;

  assign csel_ok   = (csel != 3'd0) && (csel <= NBanks);
  assign hsel_bank = (hsel != 3'd0) && (hsel <= NBanks);
  assign hsel_bad  = hsel > NBanks;
  assign cidx      = csel - 3'd1;
  assign hidx      = hsel - 3'd1;

  // Host may only write while idle; the engine owns the banks in every state.
  assign host_wr_ok   = hwr && (state == IDLE) && !hsel_bad;
  assign img_we       = host_wr_ok && (hsel == 3'd0);
  assign host_bank_we = host_wr_ok && hsel_bank;
  assign eng_we       = cwr && csel_ok;
  assign collide      = host_bank_we && eng_we && (hsel == csel) && (haddr == caddr_wr);

`ifdef CONV_RSP_WDOG_EN
  localparam int                CntW     = $clog2(WDOG_CYCLES + 1);
  localparam logic [CntW-1:0]   WdogLast = CntW'(WDOG_CYCLES - 1);
  logic [CntW-1:0] wdog_cnt;
  assign wdog_expire = (state == READY) && !busy && (wdog_cnt == WdogLast);
`else
  assign wdog_expire = 1'b0;
`endif

  assign err_set = ((cwr || crd) && !csel_ok)
                 || (hwr && (state != IDLE))
                 || ((hwr || hrd) && hsel_bad)
                 || collide
                 || wdog_expire;

  // Engine write is issued after the host write so it wins on a same-address collision.
  always_ff @(posedge clk) begin
    if (img_we) img_mem[haddr] <= hwdata;
    if (host_bank_we) bank_mem[hidx][haddr] <= hwdata;
    if (eng_we) bank_mem[cidx][caddr_wr] <= cdata_wr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idata    <= '0;
      cdata_rd <= '0;
      hrdata   <= '0;
    end else begin
      idata <= img_mem[iaddr];
      if (crd) cdata_rd <= csel_ok ? bank_mem[cidx][caddr_rd] : '0;
      if (hrd) begin
        if (hsel == 3'd0) hrdata <= img_mem[haddr];
        else if (hsel_bank) hrdata <= bank_mem[hidx][haddr];
        else hrdata <= '0;
      end
    end
  end

  // A new error raised in the start cycle survives the clear that start performs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ready <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef CONV_RSP_WDOG_EN
      wdog_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= err | err_set;
      case (state)
        IDLE: begin
          if (start) begin
            state <= READY;
            ready <= 1'b1;
            err   <= err_set;
`ifdef CONV_RSP_WDOG_EN
            wdog_cnt <= '0;
`endif
          end
        end
        READY: begin
          if (busy) begin
            state <= RUN;
            ready <= 1'b0;
          end
`ifdef CONV_RSP_WDOG_EN
          else if (wdog_expire) begin
            state <= IDLE;
            ready <= 1'b0;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
`endif
        end
        RUN: begin
          if (!busy) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
